multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have parameter ILLEGAL_HALT, default 1; 1 = an illegal opcode enters HALT, 0 = an illegal opcode flags illegal_op and returns to FETCH.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock, rising-edge active.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port opcode, input, 6 bits: instruction register bits [31:26].
REQ-005 The block SHALL have the following 1-bit outputs: pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a.
REQ-006 The block SHALL have the following 2-bit outputs: alu_op (to the ALU control decoder), alu_src_b, pc_source.
REQ-007 The block SHALL have port illegal_op, output, 1 bit: pulses for one cycle when DECODE sees an unsupported opcode.
REQ-008 The block SHALL have port state, output, 4 bits: the current state, for debug and verification.

Function
REQ-009 The block SHALL be a Moore FSM; all control outputs SHALL decode from the current state only, and every output not listed for a state SHALL be 0.
REQ-010 The block SHALL use the following state encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11, HALT=15.
REQ-011 FETCH SHALL assert mem_read=1, ir_write=1, alu_src_b=01, alu_op=00, pc_write=1, pc_source=00, and SHALL go to DECODE.
REQ-012 DECODE SHALL assert alu_src_b=11 and alu_op=00 (branch target computation), and SHALL sample opcode to select the next state:
- 000000 -> EXEC
- 100011 or 101011 -> MEMADR
- 000100 -> BRANCH
- 000010 -> JUMP
- 001000 -> ADDI_EX
- any other opcode -> illegal handling per REQ-020.
REQ-013 MEMADR SHALL assert alu_src_a=1, alu_src_b=10, alu_op=00; it SHALL go to MEMRD if opcode=100011, otherwise to MEMWR.
REQ-014 MEMRD SHALL assert mem_read=1 and i_or_d=1, then go to MEMWB; MEMWB SHALL assert reg_write=1 and mem_to_reg=1 (reg_dst=0), then go to FETCH.
REQ-015 MEMWR SHALL assert mem_write=1 and i_or_d=1, then go to FETCH.
REQ-016 EXEC SHALL assert alu_src_a=1, alu_src_b=00, alu_op=10, then go to RWB; RWB SHALL assert reg_write=1 and reg_dst=1, then go to FETCH.
REQ-017 BRANCH SHALL assert alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, then go to FETCH.
REQ-018 JUMP SHALL assert pc_write=1 and pc_source=10, then go to FETCH.
REQ-019 ADDI_EX SHALL assert alu_src_a=1, alu_src_b=10, alu_op=00, then go to ADDI_WB; ADDI_WB SHALL assert reg_write=1 (reg_dst=0, mem_to_reg=0), then go to FETCH.
REQ-020 On an illegal opcode in DECODE, illegal_op SHALL be 1 for exactly that DECODE cycle; the next state SHALL be HALT if ILLEGAL_HALT=1, otherwise FETCH.
REQ-021 HALT SHALL drive all control outputs to 0 and remain in HALT until reset.
REQ-022 Instruction latency from FETCH entry to the next FETCH entry SHALL be: lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles.
REQ-023 opcode SHALL be ignored in every state except DECODE and MEMADR.
REQ-024 pc_write and mem_write SHALL never both be 1 in the same cycle, and mem_read and mem_write SHALL never both be 1 in the same cycle.
REQ-025 A 2-bit field SHALL never take an encoding not listed above; specifically, pc_source=11 and alu_op=11 SHALL never be driven.

Reset
REQ-026 rst_n=0 SHALL force state=FETCH immediately, without waiting for a clock edge, from any state including HALT and mid-instruction.
REQ-027 While rst_n=0, all control outputs and illegal_op SHALL be 0.
REQ-028 On the first rising clk edge with rst_n=1, the FETCH outputs SHALL be asserted and the FSM SHALL proceed normally.

Verification
REQ-029 Release reset, opcode=100011 -> state sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
REQ-030 opcode=000000 -> states 0,1,6,7,0; alu_op=10 in state 6; reg_dst=1 and reg_write=1 in state 7.
REQ-031 opcode=000100, then opcode=000010 -> states 0,1,8,0 with pc_write_cond=1 and pc_source=01 in state 8; then 0,1,9,0 with pc_source=10 in state 9.
REQ-032 opcode=111111 with ILLEGAL_HALT=1 -> illegal_op=1 in DECODE, then state=15 held for at least 10 cycles with all outputs 0; repeat with ILLEGAL_HALT=0 -> state returns to 0.
REQ-033 Assert rst_n=0 asynchronously while in MEMWR (state 5) -> state=0 and mem_write=0 before the next clk edge; after release, normal fetch resumes.
REQ-034 The bench SHALL run random opcodes for 10k cycles and check REQ-024, REQ-025 and the latencies of REQ-022 on every cycle.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control unit for a multicycle MIPS-style datapath.
// Moore FSM: every datapath control line is a pure function of the current
// state. The only opcode-dependent output is the one-cycle illegal_op flag
// raised while DECODE is looking at an unsupported opcode.
// While rst_n is low every output is forced to 0, even though the state
// register already holds FETCH.
module multicycle_control #(
    // 1: an illegal opcode parks the FSM in HALT until reset.
    // 0: an illegal opcode is flagged and the FSM returns to FETCH.
    parameter int unsigned ILLEGAL_HALT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       alu_src_a,
    output logic [1:0] alu_op,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11,
        S_HALT    = 4'd15
    } state_e;

    // Supported opcodes (instruction bits [31:26]).
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ALU operation codes handed to the ALU control decoder.
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // ALU B operand select.
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    // PC source select.
    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_OUT  = 2'b01;
    localparam logic [1:0] PCSRC_JUMP = 2'b10;

    state_e state_q;
    state_e state_d;
    logic   opcode_legal;

    // Ungated control values decoded from the current state.
    logic       pc_write_s;
    logic       pc_write_cond_s;
    logic       i_or_d_s;
    logic       mem_read_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       mem_to_reg_s;
    logic       reg_write_s;
    logic       reg_dst_s;
    logic       alu_src_a_s;
    logic [1:0] alu_op_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] pc_source_s;

    // State register; reset lands in FETCH without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Classify the opcode as one of the six supported instructions.
    always_comb begin
        opcode_legal = 1'b0;
        case (opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: opcode_legal = 1'b1;
            default:                                       opcode_legal = 1'b0;
        endcase
    end

    // Next-state logic; opcode is only consulted in DECODE and MEMADR.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    default:      state_d = (ILLEGAL_HALT != 0) ? S_HALT : S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWB;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   state_d = S_FETCH;
            S_EXEC:    state_d = S_RWB;
            S_RWB:     state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            S_ADDI_EX: state_d = S_ADDI_WB;
            S_ADDI_WB: state_d = S_FETCH;
            S_HALT:    state_d = S_HALT;
            // Unused encodings recover to FETCH.
            default:   state_d = S_FETCH;
        endcase
    end

    // Moore output decode; anything not named for a state stays 0.
    always_comb begin
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        i_or_d_s        = 1'b0;
        mem_read_s      = 1'b0;
        mem_write_s     = 1'b0;
        ir_write_s      = 1'b0;
        mem_to_reg_s    = 1'b0;
        reg_write_s     = 1'b0;
        reg_dst_s       = 1'b0;
        alu_src_a_s     = 1'b0;
        alu_op_s        = ALU_ADD;
        alu_src_b_s     = SRCB_REG;
        pc_source_s     = PCSRC_ALU;
        case (state_q)
            S_FETCH: begin
                // Read instruction, latch IR, PC <= PC + 4.
                mem_read_s  = 1'b1;
                ir_write_s  = 1'b1;
                alu_src_b_s = SRCB_FOUR;
                alu_op_s    = ALU_ADD;
                pc_write_s  = 1'b1;
                pc_source_s = PCSRC_ALU;
            end
            S_DECODE: begin
                // Speculatively compute the branch target.
                alu_src_b_s = SRCB_BOFF;
                alu_op_s    = ALU_ADD;
            end
            S_MEMADR, S_ADDI_EX: begin
                // rs + sign-extended immediate.
                alu_src_a_s = 1'b1;
                alu_src_b_s = SRCB_IMM;
                alu_op_s    = ALU_ADD;
            end
            S_MEMRD: begin
                mem_read_s = 1'b1;
                i_or_d_s   = 1'b1;
            end
            S_MEMWB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b1;
            end
            S_MEMWR: begin
                mem_write_s = 1'b1;
                i_or_d_s    = 1'b1;
            end
            S_EXEC: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = SRCB_REG;
                alu_op_s    = ALU_FUNCT;
            end
            S_RWB: begin
                reg_write_s = 1'b1;
                reg_dst_s   = 1'b1;
            end
            S_BRANCH: begin
                // Compare rs - rt; PC takes the target computed in DECODE.
                alu_src_a_s     = 1'b1;
                alu_src_b_s     = SRCB_REG;
                alu_op_s        = ALU_SUB;
                pc_write_cond_s = 1'b1;
                pc_source_s     = PCSRC_OUT;
            end
            S_JUMP: begin
                pc_write_s  = 1'b1;
                pc_source_s = PCSRC_JUMP;
            end
            S_ADDI_WB: begin
                reg_write_s = 1'b1;
            end
            default: begin
                // HALT and unused encodings drive nothing.
            end
        endcase
    end

    // Reset holds every output low regardless of the (FETCH) state.
    assign pc_write      = rst_n & pc_write_s;
    assign pc_write_cond = rst_n & pc_write_cond_s;
    assign i_or_d        = rst_n & i_or_d_s;
    assign mem_read      = rst_n & mem_read_s;
    assign mem_write     = rst_n & mem_write_s;
    assign ir_write      = rst_n & ir_write_s;
    assign mem_to_reg    = rst_n & mem_to_reg_s;
    assign reg_write     = rst_n & reg_write_s;
    assign reg_dst       = rst_n & reg_dst_s;
    assign alu_src_a     = rst_n & alu_src_a_s;
    assign alu_op        = rst_n ? alu_op_s    : 2'b00;
    assign alu_src_b     = rst_n ? alu_src_b_s : 2'b00;
    assign pc_source     = rst_n ? pc_source_s : 2'b00;

    // Illegal flag lives only for the DECODE cycle that sees the bad opcode.
    assign illegal_op = rst_n & (state_q == S_DECODE) & ~opcode_legal;

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed and random checks of the multicycle control FSM. Two instances:
// u_dut_h parks in HALT on an illegal opcode, u_dut_f returns to FETCH.
module tb_multicycle_control;

    // Control word packing: {pc_write, pc_write_cond, i_or_d, mem_read,
    // mem_write, ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a,
    // alu_op[1:0], alu_src_b[1:0], pc_source[1:0]}
    localparam logic [15:0] C_FETCH  = 16'b1_0_0_1_0_1_0_0_0_0_00_01_00;
    localparam logic [15:0] C_DECODE = 16'b0_0_0_0_0_0_0_0_0_0_00_11_00;
    localparam logic [15:0] C_MEMADR = 16'b0_0_0_0_0_0_0_0_0_1_00_10_00;
    localparam logic [15:0] C_MEMRD  = 16'b0_0_1_1_0_0_0_0_0_0_00_00_00;
    localparam logic [15:0] C_MEMWB  = 16'b0_0_0_0_0_0_1_1_0_0_00_00_00;
    localparam logic [15:0] C_MEMWR  = 16'b0_0_1_0_1_0_0_0_0_0_00_00_00;
    localparam logic [15:0] C_EXEC   = 16'b0_0_0_0_0_0_0_0_0_1_10_00_00;
    localparam logic [15:0] C_RWB    = 16'b0_0_0_0_0_0_0_1_1_0_00_00_00;
    localparam logic [15:0] C_BRANCH = 16'b0_1_0_0_0_0_0_0_0_1_01_00_01;
    localparam logic [15:0] C_JUMP   = 16'b1_0_0_0_0_0_0_0_0_0_00_00_10;
    localparam logic [15:0] C_ADDIEX = 16'b0_0_0_0_0_0_0_0_0_1_00_10_00;
    localparam logic [15:0] C_ADDIWB = 16'b0_0_0_0_0_0_0_1_0_0_00_00_00;
    localparam logic [15:0] C_ZERO   = 16'b0;

    logic clk;
    int   n_pass;
    int   n_total;

    // ---------------- DUT h (ILLEGAL_HALT = 1) ----------------
    logic       h_rst_n;
    logic [5:0] h_opcode;
    logic       h_pc_write, h_pc_write_cond, h_i_or_d, h_mem_read, h_mem_write;
    logic       h_ir_write, h_mem_to_reg, h_reg_write, h_reg_dst, h_alu_src_a;
    logic [1:0] h_alu_op, h_alu_src_b, h_pc_source;
    logic       h_illegal_op;
    logic [3:0] h_state;
    logic [15:0] h_ctrl;

    multicycle_control #(.ILLEGAL_HALT(1)) u_dut_h (
        .clk(clk), .rst_n(h_rst_n), .opcode(h_opcode),
        .pc_write(h_pc_write), .pc_write_cond(h_pc_write_cond), .i_or_d(h_i_or_d),
        .mem_read(h_mem_read), .mem_write(h_mem_write), .ir_write(h_ir_write),
        .mem_to_reg(h_mem_to_reg), .reg_write(h_reg_write), .reg_dst(h_reg_dst),
        .alu_src_a(h_alu_src_a), .alu_op(h_alu_op), .alu_src_b(h_alu_src_b),
        .pc_source(h_pc_source), .illegal_op(h_illegal_op), .state(h_state)
    );

    assign h_ctrl = {h_pc_write, h_pc_write_cond, h_i_or_d, h_mem_read, h_mem_write,
                     h_ir_write, h_mem_to_reg, h_reg_write, h_reg_dst, h_alu_src_a,
                     h_alu_op, h_alu_src_b, h_pc_source};

    // ---------------- DUT f (ILLEGAL_HALT = 0) ----------------
    logic       f_rst_n;
    logic [5:0] f_opcode;
    logic       f_pc_write, f_pc_write_cond, f_i_or_d, f_mem_read, f_mem_write;
    logic       f_ir_write, f_mem_to_reg, f_reg_write, f_reg_dst, f_alu_src_a;
    logic [1:0] f_alu_op, f_alu_src_b, f_pc_source;
    logic       f_illegal_op;
    logic [3:0] f_state;
    logic [15:0] f_ctrl;

    multicycle_control #(.ILLEGAL_HALT(0)) u_dut_f (
        .clk(clk), .rst_n(f_rst_n), .opcode(f_opcode),
        .pc_write(f_pc_write), .pc_write_cond(f_pc_write_cond), .i_or_d(f_i_or_d),
        .mem_read(f_mem_read), .mem_write(f_mem_write), .ir_write(f_ir_write),
        .mem_to_reg(f_mem_to_reg), .reg_write(f_reg_write), .reg_dst(f_reg_dst),
        .alu_src_a(f_alu_src_a), .alu_op(f_alu_op), .alu_src_b(f_alu_src_b),
        .pc_source(f_pc_source), .illegal_op(f_illegal_op), .state(f_state)
    );

    assign f_ctrl = {f_pc_write, f_pc_write_cond, f_i_or_d, f_mem_read, f_mem_write,
                     f_ir_write, f_mem_to_reg, f_reg_write, f_reg_dst, f_alu_src_a,
                     f_alu_op, f_alu_src_b, f_pc_source};

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles from one FETCH entry to the next for a given opcode.
    function automatic int lat_of(input logic [5:0] op);
        case (op)
            6'b100011:                     return 5;
            6'b101011, 6'b000000, 6'b001000: return 4;
            6'b000100, 6'b000010:          return 3;
            default:                       return 2;
        endcase
    endfunction

    // Both instances in reset; outputs low; h released into FETCH.
    task automatic test_reset();
        h_rst_n = 1'b0; f_rst_n = 1'b0; h_opcode = 6'd0; f_opcode = 6'd0;
        #1;
        n_total++;
        if (h_state !== 4'd0 || h_ctrl !== C_ZERO || h_illegal_op !== 1'b0)
            $display("FAIL reset_h got state=%0d ctrl=%b ill=%b want state=0 ctrl=0 ill=0",
                     h_state, h_ctrl, h_illegal_op);
        else n_pass++;
        n_total++;
        if (f_state !== 4'd0 || f_ctrl !== C_ZERO || f_illegal_op !== 1'b0)
            $display("FAIL reset_f got state=%0d ctrl=%b ill=%b want state=0 ctrl=0 ill=0",
                     f_state, f_ctrl, f_illegal_op);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (h_state !== 4'd0 || h_ctrl !== C_ZERO)
            $display("FAIL reset_hold got state=%0d ctrl=%b want state=0 ctrl=0", h_state, h_ctrl);
        else n_pass++;
        h_rst_n = 1'b1;
        #1;
        n_total++;
        if (h_state !== 4'd0 || h_ctrl !== C_FETCH)
            $display("FAIL reset_release got state=%0d ctrl=%b want state=0 ctrl=%b",
                     h_state, h_ctrl, C_FETCH);
        else n_pass++;
    endtask

    task automatic test_lw();
        logic [3:0]  st[6];
        logic [15:0] cw[6];
        st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        cw = '{C_FETCH, C_DECODE, C_MEMADR, C_MEMRD, C_MEMWB, C_FETCH};
        h_opcode = 6'b100011;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            n_total++;
            if (h_state !== st[i] || h_ctrl !== cw[i])
                $display("FAIL lw[%0d] got state=%0d ctrl=%b want state=%0d ctrl=%b",
                         i, h_state, h_ctrl, st[i], cw[i]);
            else n_pass++;
        end
    endtask

    task automatic test_sw();
        logic [3:0]  st[5];
        logic [15:0] cw[5];
        st = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
        cw = '{C_FETCH, C_DECODE, C_MEMADR, C_MEMWR, C_FETCH};
        h_opcode = 6'b101011;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            n_total++;
            if (h_state !== st[i] || h_ctrl !== cw[i])
                $display("FAIL sw[%0d] got state=%0d ctrl=%b want state=%0d ctrl=%b",
                         i, h_state, h_ctrl, st[i], cw[i]);
            else n_pass++;
        end
    endtask

    task automatic test_rtype();
        logic [3:0]  st[5];
        logic [15:0] cw[5];
        st = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        cw = '{C_FETCH, C_DECODE, C_EXEC, C_RWB, C_FETCH};
        h_opcode = 6'b000000;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            // Opcode is irrelevant after DECODE; scramble it in EXEC.
            if (i == 2) h_opcode = 6'b100011;
            n_total++;
            if (h_state !== st[i] || h_ctrl !== cw[i])
                $display("FAIL rtype[%0d] got state=%0d ctrl=%b want state=%0d ctrl=%b",
                         i, h_state, h_ctrl, st[i], cw[i]);
            else n_pass++;
        end
    endtask

    task automatic test_beq_j();
        logic [3:0]  st[7];
        logic [15:0] cw[7];
        st = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd9, 4'd0};
        cw = '{C_FETCH, C_DECODE, C_BRANCH, C_FETCH, C_DECODE, C_JUMP, C_FETCH};
        h_opcode = 6'b000100;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 3) h_opcode = 6'b000010;
            n_total++;
            if (h_state !== st[i] || h_ctrl !== cw[i])
                $display("FAIL beq_j[%0d] got state=%0d ctrl=%b want state=%0d ctrl=%b",
                         i, h_state, h_ctrl, st[i], cw[i]);
            else n_pass++;
        end
    endtask

    task automatic test_addi();
        logic [3:0]  st[5];
        logic [15:0] cw[5];
        st = '{4'd0, 4'd1, 4'd10, 4'd11, 4'd0};
        cw = '{C_FETCH, C_DECODE, C_ADDIEX, C_ADDIWB, C_FETCH};
        h_opcode = 6'b001000;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            n_total++;
            if (h_state !== st[i] || h_ctrl !== cw[i])
                $display("FAIL addi[%0d] got state=%0d ctrl=%b want state=%0d ctrl=%b",
                         i, h_state, h_ctrl, st[i], cw[i]);
            else n_pass++;
        end
    endtask

    // Illegal opcode on the halting instance; it must stay parked.
    task automatic test_halt();
        h_opcode = 6'b111111;
        n_total++;
        if (h_state !== 4'd0 || h_illegal_op !== 1'b0)
            $display("FAIL halt_fetch got state=%0d ill=%b want state=0 ill=0", h_state, h_illegal_op);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (h_state !== 4'd1 || h_illegal_op !== 1'b1 || h_ctrl !== C_DECODE)
            $display("FAIL halt_decode got state=%0d ill=%b ctrl=%b want state=1 ill=1 ctrl=%b",
                     h_state, h_illegal_op, h_ctrl, C_DECODE);
        else n_pass++;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            h_opcode = 6'($urandom_range(0, 63));
            n_total++;
            if (h_state !== 4'd15 || h_ctrl !== C_ZERO || h_illegal_op !== 1'b0)
                $display("FAIL halt_hold[%0d] got state=%0d ctrl=%b ill=%b want state=15 ctrl=0 ill=0",
                         i, h_state, h_ctrl, h_illegal_op);
            else n_pass++;
        end
    endtask

    // Illegal opcode on the non-halting instance returns to FETCH.
    task automatic test_illegal_fetch();
        f_opcode = 6'b111111;
        f_rst_n = 1'b1;
        #1;
        n_total++;
        if (f_state !== 4'd0 || f_ctrl !== C_FETCH || f_illegal_op !== 1'b0)
            $display("FAIL illf_fetch got state=%0d ctrl=%b ill=%b want state=0 ctrl=%b ill=0",
                     f_state, f_ctrl, f_illegal_op, C_FETCH);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (f_state !== 4'd1 || f_illegal_op !== 1'b1 || f_ctrl !== C_DECODE)
            $display("FAIL illf_decode got state=%0d ill=%b ctrl=%b want state=1 ill=1 ctrl=%b",
                     f_state, f_illegal_op, f_ctrl, C_DECODE);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (f_state !== 4'd0 || f_illegal_op !== 1'b0 || f_ctrl !== C_FETCH)
            $display("FAIL illf_return got state=%0d ill=%b ctrl=%b want state=0 ill=0 ctrl=%b",
                     f_state, f_illegal_op, f_ctrl, C_FETCH);
        else n_pass++;
    endtask

    // Reset out of HALT, then an asynchronous reset in the middle of MEMWR.
    task automatic test_async_reset();
        @(negedge clk);
        h_rst_n = 1'b0;
        #1;
        n_total++;
        if (h_state !== 4'd0 || h_ctrl !== C_ZERO)
            $display("FAIL rst_from_halt got state=%0d ctrl=%b want state=0 ctrl=0", h_state, h_ctrl);
        else n_pass++;
        h_opcode = 6'b101011;
        h_rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if (h_state !== 4'd5 || h_mem_write !== 1'b1)
            $display("FAIL arst_memwr got state=%0d mem_write=%b want state=5 mem_write=1",
                     h_state, h_mem_write);
        else n_pass++;
        #1 h_rst_n = 1'b0;
        #1;
        n_total++;
        if (h_state !== 4'd0 || h_mem_write !== 1'b0 || h_ctrl !== C_ZERO)
            $display("FAIL arst_async got state=%0d mem_write=%b ctrl=%b want state=0 mem_write=0 ctrl=0",
                     h_state, h_mem_write, h_ctrl);
        else n_pass++;
        #1 h_rst_n = 1'b1;
        h_opcode = 6'b000010;
        #1;
        n_total++;
        if (h_state !== 4'd0 || h_ctrl !== C_FETCH)
            $display("FAIL arst_release got state=%0d ctrl=%b want state=0 ctrl=%b", h_state, h_ctrl, C_FETCH);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (h_state !== 4'd1)
            $display("FAIL arst_decode got state=%0d want state=1", h_state);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (h_state !== 4'd9 || h_ctrl !== C_JUMP)
            $display("FAIL arst_jump got state=%0d ctrl=%b want state=9 ctrl=%b", h_state, h_ctrl, C_JUMP);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (h_state !== 4'd0)
            $display("FAIL arst_refetch got state=%0d want state=0", h_state);
        else n_pass++;
    endtask

    // Random opcodes on the non-halting instance: per-cycle exclusivity and
    // encoding checks, plus FETCH-to-FETCH latency per instruction.
    task automatic test_random();
        int         cyc;
        bit         seen;
        logic [5:0] dec_op;
        int         exp_lat;
        logic [5:0] legal[6];
        legal  = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
        cyc    = 0;
        seen   = 1'b0;
        dec_op = 6'd0;
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            n_total++;
            if (f_pc_write && f_mem_write)
                $display("FAIL rnd_pcw_memw cycle %0d got both=1 want not both", n);
            else n_pass++;
            n_total++;
            if (f_mem_read && f_mem_write)
                $display("FAIL rnd_memr_memw cycle %0d got both=1 want not both", n);
            else n_pass++;
            n_total++;
            if (f_pc_source === 2'b11 || f_alu_op === 2'b11)
                $display("FAIL rnd_encoding cycle %0d got pc_source=%b alu_op=%b want neither 11",
                         n, f_pc_source, f_alu_op);
            else n_pass++;
            cyc++;
            if (f_state == 4'd1) dec_op = f_opcode;
            if (f_state == 4'd0) begin
                if (seen) begin
                    exp_lat = lat_of(dec_op);
                    n_total++;
                    if (cyc != exp_lat)
                        $display("FAIL rnd_latency op=%b got %0d want %0d", dec_op, cyc, exp_lat);
                    else n_pass++;
                end
                seen = 1'b1;
                cyc  = 0;
            end else if (cyc > 6) begin
                n_total++;
                $display("FAIL rnd_watchdog state=%0d got %0d cycles without FETCH want <=5", f_state, cyc);
                seen = 1'b0;
                cyc  = 0;
            end
            if (f_state != 4'd1 && f_state != 4'd2) begin
                if ($urandom_range(0, 1) == 0) f_opcode = legal[$urandom_range(0, 5)];
                else f_opcode = 6'($urandom_range(0, 63));
            end
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_lw();
        test_sw();
        test_rtype();
        test_beq_j();
        test_addi();
        test_halt();
        test_illegal_fetch();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
